hdlc_tx_ctrl: RTL and testbench
===============================

# hdlc_tx_ctrl

HDLC transmit frame controller. Sequences one frame per request on the serial line: opening flag, LSB-first payload bytes pulled from the TX buffer with zero-bit insertion, closing flag, or an abort sequence. Sits between the TX buffer/register interface (clk_i domain) and the line driver. Bit timing comes from a one-cycle bit strobe generated by the baud divider.

## Interface
- ABORT_LEN, 8: number of consecutive 1s sent as the abort sequence (legal ≥ 7).
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- txen_i  in  1  transmitter enable; low forces IDLE.
- txclk_en_i  in  1  bit strobe; one bit is emitted per strobe.
- start_i  in  1  frame request pulse; accepted only in IDLE.
- abort_i  in  1  abort request pulse; honoured in OFLAG/DATA/CFLAG.
- byte_i  in  8  payload byte from TX buffer.
- byte_last_i  in  1  qualifies byte_i as the final payload byte.
- byte_valid_i  in  1  byte_i/byte_last_i valid.
- byte_rdy_o  out  1  controller can accept a byte; transfer on valid && rdy.
- tx_o  out  1  serial line, registered.
- frame_o  out  1  high from first opening-flag bit through last closing-flag or abort bit.
- busy_o  out  1  state ≠ IDLE.
- txdone_o  out  1  one-cycle pulse, frame completed normally.
- abortframe_o  out  1  one-cycle pulse, abort sequence completed.

## Operation
- Reset values: state IDLE, tx_o=1, all other outputs 0, holding register empty, counters 0.
- States: IDLE, OFLAG, DATA, CFLAG, ABORT.
- IDLE: tx_o=1 (mark). start_i && txen_i → OFLAG. start_i with simultaneous abort_i: start wins, abort ignored. start_i outside IDLE ignored.
- OFLAG/CFLAG: send 0x7E LSB-first, 8 strobes, no stuffing; ones counter cleared.
- Holding register (1 byte): byte_rdy_o = (state ∈ {OFLAG, DATA}) && holding empty && no last byte already taken.
- Byte boundary = strobe emitting bit 7 of the flag (OFLAG) or of the current data byte (DATA). At it: holding full → load shifter, DATA; current byte was last → CFLAG; else underrun → ABORT.
- DATA: emit shifter LSB first. Ones counter increments on each data 1, clears on 0. After the 5th consecutive 1, the next strobe emits a stuffed 0 (shifter holds, counter clears). Stuffing also applies after the final data bit, before CFLAG.
- CFLAG end → IDLE, txdone_o pulse.
- abort_i in OFLAG/DATA/CFLAG → ABORT at next strobe, mid-byte allowed; holding register flushed. ABORT emits ABORT_LEN 1s, then IDLE with abortframe_o pulse. abort_i during ABORT is ignored.
- txen_i low in any state → IDLE next cycle, tx_o=1, holding flushed, no pulses.

## Timing
- All outputs registered. tx_o/frame_o update the cycle after the strobe that emits the bit.
- start_i at cycle t: OFLAG from t+1. The first flag bit appears on the first strobe after t.
- frame_o rises with the first flag bit and falls the cycle after the last flag/abort bit strobe. txdone_o/abortframe_o are asserted in that same cycle.
- Ones counter is 3 bits, saturates at 5. Bit counter is 3 bits and wraps 7→0 at byte boundaries. Stuffed bits do not advance the bit counter.
- Strobes are assumed ≥ 2 cycles apart. Byte must arrive before the boundary strobe to avoid underrun.

## Structure
- hdlc_pkg: state enum, FLAG = 8'h7E, STUFF_LIMIT = 5.
- Sub-module hdlc_bitstuff: ones counter and stuff-request flag. Controller FSM, shifter and holding register stay in hdlc_tx_ctrl.

## Test plan
- Single byte 0x00 with last → tx bits 01111110 00000000 01111110. frame_o high for 24 strobes, one txdone_o.
- Single byte 0xFF with last → data 11111 0 111 (9 bits), closing flag unstuffed. frame_o high 25 strobes.
- Bytes 0x1F, 0xF8 (last) → 11111 0 000, 00011111 0, then flag. Covers stuffing at byte boundary and before the closing flag.
- Byte 0x55 without last, byte_valid_i low afterwards → eight 1s after byte, abortframe_o pulse, no txdone_o.
- abort_i at 3rd bit of byte 2 → next strobe starts ABORT_LEN 1s. byte_rdy_o low; new start_i accepted only after abortframe_o.
- rst_n_i low mid-DATA → tx_o=1 and outputs 0 immediately. After release, start_i produces a clean frame. Repeat with txen_i low mid-frame.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit path.
// Holds the controller state encoding, the flag pattern and the zero-insertion run limit.
package hdlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OFLAG = 3'd1,
        ST_DATA  = 3'd2,
        ST_CFLAG = 3'd3,
        ST_ABORT = 3'd4
    } tx_state_t;

    localparam logic [7:0] FLAG        = 8'h7E;
    localparam logic [2:0] STUFF_LIMIT = 3'd5;

    // True when emitting bit_val on top of a run of `ones` forces a stuffed zero next.
    function automatic logic stuff_after(input logic [2:0] ones, input logic bit_val);
        return bit_val && (ones == STUFF_LIMIT - 3'd1);
    endfunction

endpackage

// File: rtl/hdlc_bitstuff.sv
// Consecutive-ones tracker for HDLC zero-bit insertion.
// stuff_req is high once STUFF_LIMIT data ones have gone out back to back.
module hdlc_bitstuff
    import hdlc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift,
    input  logic       bit_val,
    output logic [2:0] ones_cnt,
    output logic       stuff_req
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= 3'd0;
        end else if (clr) begin
            ones_cnt <= 3'd0;
        end else if (shift) begin
            if (!bit_val) begin
                ones_cnt <= 3'd0;
            end else if (ones_cnt != STUFF_LIMIT) begin
                ones_cnt <= ones_cnt + 3'd1;
            end
        end
    end

    assign stuff_req = (ones_cnt == STUFF_LIMIT);

endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit frame controller: opening flag, LSB-first stuffed payload, closing flag or abort.
// Byte intake is valid/ready: a byte moves into the holding register on any cycle where byte_valid_i && byte_rdy_o.
module hdlc_tx_ctrl
    import hdlc_pkg::*;
#(
    parameter int ABORT_LEN = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       txen_i,
    input  logic       txclk_en_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] byte_i,
    input  logic       byte_last_i,
    input  logic       byte_valid_i,
    output logic       byte_rdy_o,
    output logic       tx_o,
    output logic       frame_o,
    output logic       busy_o,
    output logic       txdone_o,
    output logic       abortframe_o,
    output logic [2:0] dbg_state
);

    localparam int ACW = $clog2(ABORT_LEN);
    localparam logic [ACW-1:0] ABORT_LAST = ACW'(ABORT_LEN - 1);

    tx_state_t      state, state_n;
    logic [7:0]     shifter, shifter_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     hold_data, hold_data_n;
    logic           hold_last, hold_last_n;
    logic           hold_full, hold_full_n;
    logic           cur_last, cur_last_n;
    logic           last_seen, last_seen_n;
    logic           tail, tail_n;
    logic [ACW-1:0] abort_cnt, abort_cnt_n;
    logic           tx_n, frame_n, txdone_n, abortframe_n, rdy_n, busy_n;

    logic           ones_clr, ones_shift, ones_bit;
    logic [2:0]     ones_cnt;
    logic           stuff_req;
    logic           abort_req;

    hdlc_bitstuff u_bitstuff (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clr       (ones_clr),
        .shift     (ones_shift),
        .bit_val   (ones_bit),
        .ones_cnt  (ones_cnt),
        .stuff_req (stuff_req)
    );

    assign abort_req = abort_i &&
                       ((state == ST_OFLAG) || (state == ST_DATA) || (state == ST_CFLAG));
    assign dbg_state = state;

    always_comb begin
        state_n      = state;
        shifter_n    = shifter;
        bit_cnt_n    = bit_cnt;
        hold_data_n  = hold_data;
        hold_last_n  = hold_last;
        hold_full_n  = hold_full;
        cur_last_n   = cur_last;
        last_seen_n  = last_seen;
        tail_n       = tail;
        abort_cnt_n  = abort_cnt;
        tx_n         = tx_o;
        frame_n      = frame_o;
        txdone_n     = 1'b0;
        abortframe_n = 1'b0;
        ones_clr     = 1'b0;
        ones_shift   = 1'b0;
        ones_bit     = 1'b0;

        if (byte_rdy_o && byte_valid_i) begin
            hold_data_n = byte_i;
            hold_last_n = byte_last_i;
            hold_full_n = 1'b1;
            if (byte_last_i) begin
                last_seen_n = 1'b1;
            end
        end

        if (!txen_i) begin
            state_n     = ST_IDLE;
            tx_n        = 1'b1;
            frame_n     = 1'b0;
            hold_full_n = 1'b0;
            hold_last_n = 1'b0;
            cur_last_n  = 1'b0;
            last_seen_n = 1'b0;
            tail_n      = 1'b0;
            bit_cnt_n   = 3'd0;
            abort_cnt_n = '0;
            ones_clr    = 1'b1;
        end else if (abort_req) begin
            state_n     = ST_ABORT;
            hold_full_n = 1'b0;
            hold_last_n = 1'b0;
            cur_last_n  = 1'b0;
            tail_n      = 1'b0;
            abort_cnt_n = '0;
            ones_clr    = 1'b1;
            // A strobe landing on the abort request already carries the first abort one.
            if (txclk_en_i) begin
                tx_n        = 1'b1;
                frame_n     = 1'b1;
                abort_cnt_n = ACW'(1);
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // Return to mark on a bit boundary so the last flag bit keeps its full width.
                    if (txclk_en_i) begin
                        tx_n = 1'b1;
                    end
                    if (start_i) begin
                        state_n     = ST_OFLAG;
                        bit_cnt_n   = 3'd0;
                        hold_full_n = 1'b0;
                        hold_last_n = 1'b0;
                        cur_last_n  = 1'b0;
                        last_seen_n = 1'b0;
                        tail_n      = 1'b0;
                        ones_clr    = 1'b1;
                    end
                end

                ST_OFLAG: begin
                    if (txclk_en_i) begin
                        tx_n      = FLAG[bit_cnt];
                        frame_n   = 1'b1;
                        ones_clr  = 1'b1;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (hold_full) begin
                                state_n     = ST_DATA;
                                shifter_n   = hold_data;
                                cur_last_n  = hold_last;
                                hold_full_n = 1'b0;
                            end else begin
                                state_n     = ST_ABORT;
                                abort_cnt_n = '0;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (txclk_en_i) begin
                        frame_n = 1'b1;
                        if (stuff_req) begin
                            // Inserted zero: shifter and bit counter hold.
                            tx_n     = 1'b0;
                            ones_clr = 1'b1;
                            if (tail) begin
                                state_n = ST_CFLAG;
                                tail_n  = 1'b0;
                            end
                        end else begin
                            tx_n       = shifter[0];
                            shifter_n  = {1'b0, shifter[7:1]};
                            ones_shift = 1'b1;
                            ones_bit   = shifter[0];
                            bit_cnt_n  = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (cur_last) begin
                                    // A pending stuff bit after the final data bit precedes the flag.
                                    if (stuff_after(ones_cnt, shifter[0])) begin
                                        tail_n = 1'b1;
                                    end else begin
                                        state_n = ST_CFLAG;
                                    end
                                end else if (hold_full) begin
                                    shifter_n   = hold_data;
                                    cur_last_n  = hold_last;
                                    hold_full_n = 1'b0;
                                end else begin
                                    state_n     = ST_ABORT;
                                    abort_cnt_n = '0;
                                    ones_clr    = 1'b1;
                                    ones_shift  = 1'b0;
                                end
                            end
                        end
                    end
                end

                ST_CFLAG: begin
                    if (txclk_en_i) begin
                        tx_n      = FLAG[bit_cnt];
                        ones_clr  = 1'b1;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n  = ST_IDLE;
                            frame_n  = 1'b0;
                            txdone_n = 1'b1;
                        end else begin
                            frame_n = 1'b1;
                        end
                    end
                end

                ST_ABORT: begin
                    if (txclk_en_i) begin
                        tx_n = 1'b1;
                        if (abort_cnt == ABORT_LAST) begin
                            state_n      = ST_IDLE;
                            frame_n      = 1'b0;
                            abortframe_n = 1'b1;
                            abort_cnt_n  = '0;
                        end else begin
                            frame_n     = 1'b1;
                            abort_cnt_n = abort_cnt + ACW'(1);
                        end
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        rdy_n  = ((state_n == ST_OFLAG) || (state_n == ST_DATA)) && !hold_full_n && !last_seen_n;
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            shifter      <= 8'h00;
            bit_cnt      <= 3'd0;
            hold_data    <= 8'h00;
            hold_last    <= 1'b0;
            hold_full    <= 1'b0;
            cur_last     <= 1'b0;
            last_seen    <= 1'b0;
            tail         <= 1'b0;
            abort_cnt    <= '0;
            tx_o         <= 1'b1;
            frame_o      <= 1'b0;
            busy_o       <= 1'b0;
            txdone_o     <= 1'b0;
            abortframe_o <= 1'b0;
            byte_rdy_o   <= 1'b0;
        end else begin
            state        <= state_n;
            shifter      <= shifter_n;
            bit_cnt      <= bit_cnt_n;
            hold_data    <= hold_data_n;
            hold_last    <= hold_last_n;
            hold_full    <= hold_full_n;
            cur_last     <= cur_last_n;
            last_seen    <= last_seen_n;
            tail         <= tail_n;
            abort_cnt    <= abort_cnt_n;
            tx_o         <= tx_n;
            frame_o      <= frame_n;
            busy_o       <= busy_n;
            txdone_o     <= txdone_n;
            abortframe_o <= abortframe_n;
            byte_rdy_o   <= rdy_n;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// Directed bench for hdlc_tx_ctrl: captures the serial bits of each frame and
// compares them, plus frame length and completion pulses, with hand-derived values.
module tb_hdlc_tx_ctrl;
    import hdlc_pkg::*;

    localparam int CUT_NONE = 0;
    localparam int CUT_RST  = 1;
    localparam int CUT_TXEN = 2;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       txen_i;
    logic       txclk_en_i;
    logic       start_i;
    logic       abort_i;
    logic [7:0] byte_i;
    logic       byte_last_i;
    logic       byte_valid_i;
    logic       byte_rdy_o;
    logic       tx_o;
    logic       frame_o;
    logic       busy_o;
    logic       txdone_o;
    logic       abortframe_o;
    logic [2:0] dbg_state;

    hdlc_tx_ctrl #(.ABORT_LEN(8)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .txen_i       (txen_i),
        .txclk_en_i   (txclk_en_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .byte_i       (byte_i),
        .byte_last_i  (byte_last_i),
        .byte_valid_i (byte_valid_i),
        .byte_rdy_o   (byte_rdy_o),
        .tx_o         (tx_o),
        .frame_o      (frame_o),
        .busy_o       (busy_o),
        .txdone_o     (txdone_o),
        .abortframe_o (abortframe_o),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [7:0]  feed_d[$];
    logic        feed_l[$];
    int          feed_idx;
    logic [63:0] cap;
    int          ncap;
    int          flen;
    int          n_done;
    int          n_abort;
    logic        cap_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: every call starts and ends on a falling edge.
    task automatic tick(input logic stb);
        logic hs;
        logic f_pre;
        if (feed_idx < feed_d.size()) begin
            byte_i       = feed_d[feed_idx];
            byte_last_i  = feed_l[feed_idx];
            byte_valid_i = 1'b1;
        end else begin
            byte_i       = 8'h00;
            byte_last_i  = 1'b0;
            byte_valid_i = 1'b0;
        end
        txclk_en_i = stb;
        hs         = byte_valid_i && byte_rdy_o;
        f_pre      = frame_o;
        @(negedge clk_i);
        if (hs) feed_idx++;
        txclk_en_i = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        if (txdone_o) n_done++;
        if (abortframe_o) n_abort++;
        if (stb && cap_on) begin
            cap = {cap[62:0], tx_o};
            ncap++;
            if (f_pre || frame_o) flen++;
        end
    endtask

    task automatic load_bytes(input int n, input logic [7:0] d0, input logic [7:0] d1,
                              input logic last_on_final);
        feed_d.delete();
        feed_l.delete();
        feed_idx = 0;
        feed_d.push_back(d0);
        feed_l.push_back((n == 1) ? last_on_final : 1'b0);
        if (n == 2) begin
            feed_d.push_back(d1);
            feed_l.push_back(last_on_final);
        end
    endtask

    task automatic run_frame(input int abort_at, input int cut_at, input int cut_kind);
        int k = 0;
        cap     = '0;
        ncap    = 0;
        flen    = 0;
        n_done  = 0;
        n_abort = 0;
        cap_on  = 1'b1;
        start_i = 1'b1;
        tick(1'b0);
        while (n_done == 0 && n_abort == 0 && k < 200) begin
            tick(1'b1);
            k++;
            tick(1'b0);
            if (k == abort_at) begin
                check("rdy_pre_abort", byte_rdy_o, 1);
                abort_i = 1'b1;
                tick(1'b0);
                check("rdy_post_abort", byte_rdy_o, 0);
                check("state_abort", dbg_state, ST_ABORT);
            end
            if (abort_at != 0 && k == abort_at + 2) begin
                start_i = 1'b1;
                abort_i = 1'b1;
                tick(1'b0);
                check("busy_in_abort", busy_o, 1);
                check("start_ignored_in_abort", dbg_state, ST_ABORT);
            end
            if (k == cut_at) begin
                cap_on = 1'b0;
                if (cut_kind == CUT_RST) begin
                    check("busy_before_rst", busy_o, 1);
                    #2 rst_n_i = 1'b0;
                    #1;
                    check("rst_tx", tx_o, 1);
                    check("rst_frame", frame_o, 0);
                    check("rst_busy", busy_o, 0);
                    check("rst_rdy", byte_rdy_o, 0);
                    check("rst_state", dbg_state, ST_IDLE);
                    @(negedge clk_i);
                    rst_n_i = 1'b1;
                    @(negedge clk_i);
                end else begin
                    check("busy_before_txen", busy_o, 1);
                    txen_i = 1'b0;
                    tick(1'b0);
                    check("txen_tx", tx_o, 1);
                    check("txen_frame", frame_o, 0);
                    check("txen_busy", busy_o, 0);
                    tick(1'b0);
                    tick(1'b0);
                    check("txen_no_pulse", n_done + n_abort, 0);
                    txen_i = 1'b1;
                end
                return;
            end
        end
        cap_on = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int exp_len, input int exp_flen,
                                input int exp_done, input int exp_abort);
        tick(1'b0);
        tick(1'b0);
        check({tag, "_bits"}, cap, exp_q.pop_front());
        check({tag, "_nbits"}, ncap, exp_len);
        check({tag, "_frame_len"}, flen, exp_flen);
        check({tag, "_txdone"}, n_done, exp_done);
        check({tag, "_abortframe"}, n_abort, exp_abort);
        tick(1'b1);
        tick(1'b0);
        check({tag, "_mark"}, tx_o, 1);
        check({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        rst_n_i      = 1'b0;
        txen_i       = 1'b1;
        txclk_en_i   = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        byte_i       = 8'h00;
        byte_last_i  = 1'b0;
        byte_valid_i = 1'b0;
        feed_idx     = 0;
        repeat (3) @(negedge clk_i);
        check("reset_tx", tx_o, 1);
        check("reset_frame", frame_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_rdy", byte_rdy_o, 0);
        check("reset_pulses", {txdone_o, abortframe_o}, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // 0x00 last: flag, eight zeros, flag
        load_bytes(1, 8'h00, 8'h00, 1'b1);
        exp_q.push_back(64'b011111100000000001111110);
        run_frame(0, 0, CUT_NONE);
        finish_frame("b00", 24, 24, 1, 0);

        // 0xFF last: 11111 0 111, closing flag unstuffed
        load_bytes(1, 8'hFF, 8'h00, 1'b1);
        exp_q.push_back(64'b0111111011111011101111110);
        run_frame(0, 0, CUT_NONE);
        finish_frame("bff", 25, 25, 1, 0);

        // 0x1F then 0xF8 last: stuffing mid-byte and before the closing flag
        load_bytes(2, 8'h1F, 8'hF8, 1'b1);
        exp_q.push_back(64'b0111111011111000000011111001111110);
        run_frame(0, 0, CUT_NONE);
        finish_frame("b1f_f8", 34, 34, 1, 0);

        // 0x55 without last and nothing after: underrun turns into eight ones
        load_bytes(1, 8'h55, 8'h00, 1'b0);
        exp_q.push_back(64'b011111101010101011111111);
        run_frame(0, 0, CUT_NONE);
        finish_frame("underrun", 24, 24, 0, 1);

        // abort after the third bit of byte 2
        load_bytes(2, 8'h00, 8'h00, 1'b0);
        exp_q.push_back(64'b011111100000000000011111111);
        run_frame(19, 0, CUT_NONE);
        finish_frame("abort", 27, 27, 0, 1);

        // reset in the middle of the data byte, then a clean frame
        load_bytes(2, 8'h00, 8'h00, 1'b1);
        run_frame(0, 12, CUT_RST);
        load_bytes(1, 8'h00, 8'h00, 1'b1);
        exp_q.push_back(64'b011111100000000001111110);
        run_frame(0, 0, CUT_NONE);
        finish_frame("after_rst", 24, 24, 1, 0);

        // transmitter disabled mid-frame, then a clean frame with 0x3C
        load_bytes(2, 8'h00, 8'h00, 1'b1);
        run_frame(0, 12, CUT_TXEN);
        load_bytes(1, 8'h3C, 8'h00, 1'b1);
        exp_q.push_back(64'b011111100011110001111110);
        run_frame(0, 0, CUT_NONE);
        finish_frame("after_txen", 24, 24, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
